// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port video RAM among three users in the pixel-clock domain:
//   - display scan-out reads (hard priority, 1-cycle read latency),
//   - a pixel writer on a valid/ready handshake,
//   - an internal full-screen clear engine.
//
// Optional feature: define VRAM_ARB_STALL_CNT_EN to build the 16-bit writer
// stall counter. Without it stall_cnt is tied to 0.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   disp_req/h/v          display read request and {column,row}
//   pix_data, pix_valid   display read result (0 when not valid)
//   wr_valid/ready/h/v/data  writer handshake
//   clr_start, clr_color  start a clear with the given colour
//   busy, clr_done        clear in progress / one-cycle completion pulse
//   stall_cnt             writer stall cycles (saturating)
//   ram_addr/en/we/din    RAM port ({h,v} address)
//   ram_dout              RAM read data, 1-cycle latency
module vram_arbiter #(
  parameter int H_W   = 10,
  parameter int V_W   = 9,
  parameter int DW    = 12,
  parameter int H_MAX = 640,
  parameter int V_MAX = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               disp_req,
  input  logic [H_W-1:0]     disp_h,
  input  logic [V_W-1:0]     disp_v,
  output logic [DW-1:0]      pix_data,
  output logic               pix_valid,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [H_W-1:0]     wr_h,
  input  logic [V_W-1:0]     wr_v,
  input  logic [DW-1:0]      wr_data,
  input  logic               clr_start,
  input  logic [DW-1:0]      clr_color,
  output logic               busy,
  output logic               clr_done,
  output logic [15:0]        stall_cnt,
  output logic [H_W+V_W-1:0] ram_addr,
  output logic               ram_en,
  output logic               ram_we,
  output logic [DW-1:0]      ram_din,
  input  logic [DW-1:0]      ram_dout
);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_MAX - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_MAX - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e         state_q, state_d;
  logic [H_W-1:0] ch_q, ch_d;
  logic [V_W-1:0] cv_q, cv_d;
  logic [DW-1:0]  color_q, color_d;
  logic           clr_done_q, clr_done_d;
  logic           pix_valid_q;

  // Next-state logic. Clear counters only advance in cycles the display
  // leaves the RAM free.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cv_d       = cv_q;
    color_d    = color_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          ch_d    = '0;
          cv_d    = '0;
          color_d = clr_color;
        end
      end
      CLEAR: begin
        if (!disp_req) begin
          if (ch_q != H_LAST) begin
            ch_d = ch_q + 1'b1;
          end else if (cv_q != V_LAST) begin
            ch_d = '0;
            cv_d = cv_q + 1'b1;
          end else begin
            state_d    = IDLE;
            clr_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM slot selection: reset > display > clear > writer > idle.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    wr_ready = 1'b0;
    if (!reset) begin
      if (disp_req) begin
        ram_addr = {disp_h, disp_v};
        ram_en   = 1'b1;
      end else if (state_q == CLEAR) begin
        ram_addr = {ch_q, cv_q};
        ram_din  = color_q;
        ram_en   = 1'b1;
        ram_we   = 1'b1;
      end else begin
        // Ready is offered regardless of wr_valid.
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_addr = {wr_h, wr_v};
          ram_din  = wr_data;
          ram_en   = 1'b1;
          ram_we   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      cv_q        <= '0;
      clr_done_q  <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cv_q        <= cv_d;
      clr_done_q  <= clr_done_d;
      pix_valid_q <= disp_req;
    end
  end

  // Fill colour is pure data; it is always reloaded before use.
  always_ff @(posedge clk) begin
    color_q <= color_d;
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_valid_q ? ram_dout : '0;
  assign busy      = (state_q == CLEAR);
  assign clr_done  = clr_done_q;

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  localparam int H_W = 10, V_W = 9, DW = 12, H_MAX = 4, V_MAX = 2;
  localparam int AW = H_W + V_W;

  logic          clk = 1'b0;
  logic          reset, disp_req, wr_valid, clr_start;
  logic [H_W-1:0] disp_h, wr_h;
  logic [V_W-1:0] disp_v, wr_v;
  logic [DW-1:0]  wr_data, clr_color, pix_data, ram_din, ram_dout;
  logic           pix_valid, wr_ready, busy, clr_done, ram_en, ram_we;
  logic [15:0]    stall_cnt;
  logic [AW-1:0]  ram_addr;

  always #20 clk = ~clk;

  vram_arbiter #(.H_W(H_W), .V_W(V_W), .DW(DW), .H_MAX(H_MAX), .V_MAX(V_MAX)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_h(disp_h), .disp_v(disp_v),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_h(wr_h), .wr_v(wr_v), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color),
    .busy(busy), .clr_done(clr_done), .stall_cnt(stall_cnt),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int key(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
    return int'({h, v});
  endfunction

  // Physical RAM driven by the DUT's port, and the model's view of memory.
  logic [DW-1:0] ram  [int];
  logic [DW-1:0] mmem [int];

  function automatic logic [DW-1:0] ram_rd(input int k);
    return ram.exists(k) ? ram[k] : '0;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input int k);
    return mmem.exists(k) ? mmem[k] : '0;
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[int'(ram_addr)] = ram_din;
      else        ram_dout <= ram_rd(int'(ram_addr));
    end
  end

  // Behavioural model: clear progress as a linear cell index.
  logic          m_clr = 0, m_prev = 0, m_done = 0;
  int            m_k = 0, m_stall = 0;
  logic [DW-1:0] m_color = '0, m_rd = '0;

  always @(posedge clk) begin
    bit was_clr, rdy;
    was_clr = m_clr;
    rdy     = !was_clr && !disp_req;
    if (reset) begin
      m_clr = 0; m_k = 0; m_prev = 0; m_done = 0; m_stall = 0;
    end else begin
      m_done = 0;
      if (disp_req) m_rd = mem_rd(key(disp_h, disp_v));
      m_prev = disp_req;
      if (!disp_req) begin
        if (was_clr) begin
          mmem[key(H_W'(m_k % H_MAX), V_W'(m_k / H_MAX))] = m_color;
          if (m_k == H_MAX * V_MAX - 1) begin m_clr = 0; m_done = 1; end
          else m_k++;
        end else if (wr_valid) begin
          mmem[key(wr_h, wr_v)] = wr_data;
        end
      end
      if (wr_valid && !rdy && m_stall < 65535) m_stall++;
      if (!was_clr && clr_start) begin m_clr = 1; m_k = 0; m_color = clr_color; end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      logic          e_en, e_we, e_rdy;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din;
      e_en = 0; e_we = 0; e_rdy = 0; e_addr = '0; e_din = '0;
      if (!reset) begin
        if (disp_req) begin
          e_en = 1; e_addr = {disp_h, disp_v};
        end else if (m_clr) begin
          e_en = 1; e_we = 1; e_din = m_color;
          e_addr = {H_W'(m_k % H_MAX), V_W'(m_k / H_MAX)};
        end else begin
          e_rdy = 1;
          if (wr_valid) begin e_en = 1; e_we = 1; e_addr = {wr_h, wr_v}; e_din = wr_data; end
        end
      end
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("wr_ready", 32'(wr_ready), 32'(e_rdy));
      if (!reset) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_din", 32'(ram_din), 32'(e_din));
      end
      chk("busy", 32'(busy), 32'(m_clr));
      chk("pix_valid", 32'(pix_valid), 32'(m_prev));
      chk("pix_data", 32'(pix_data), m_prev ? 32'(m_rd) : 32'h0);
      chk("clr_done", 32'(clr_done), 32'(m_done));
`ifdef VRAM_ARB_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`else
      chk("stall_cnt", 32'(stall_cnt), 32'h0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Start a clear in the current cycle, then run n cycles counting busy/clr_done.
  task automatic run_clear(input logic [DW-1:0] col, input int n, output int nb, output int nd);
    clr_start = 1; clr_color = col;
    step();
    clr_start = 0;
    nb = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      at_neg();
      nb += int'(busy); nd += int'(clr_done);
      step();
    end
  endtask

  task automatic readback(input logic [DW-1:0] col, input string nm);
    for (int v = 0; v < V_MAX; v++) begin
      for (int h = 0; h < H_MAX; h++) begin
        disp_req = 1; disp_h = H_W'(h); disp_v = V_W'(v);
        step();
        disp_req = 0;
        at_neg();
        chk(nm, 32'(pix_data), 32'(col));
        step();
      end
    end
  endtask

  initial begin
    int nb, nd;
    reset = 1; disp_req = 0; disp_h = '0; disp_v = '0;
    wr_valid = 1; wr_h = '0; wr_v = '0; wr_data = '0;
    clr_start = 0; clr_color = '0; ram_dout = '0;
    ram[key(10'd5, 9'd3)]  = 12'hABC;
    mmem[key(10'd5, 9'd3)] = 12'hABC;
    started = 1;
    step(); step();
    at_neg();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pix_valid", 32'(pix_valid), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    step();
    reset = 0; wr_valid = 0;

    // Display read
    step();
    disp_req = 1; disp_h = 10'd5; disp_v = 9'd3;
    at_neg();
    chk("rd_addr", 32'(ram_addr), 32'h00A03);
    chk("rd_we", 32'(ram_we), 32'h0);
    step();
    disp_req = 0;
    at_neg();
    chk("rd_valid", 32'(pix_valid), 32'h1);
    chk("rd_data", 32'(pix_data), 32'hABC);
    step();
    at_neg();
    chk("blank_data", 32'(pix_data), 32'h0);

    // Write handshake and read-back
    step();
    wr_valid = 1; wr_h = 10'd10; wr_v = 9'd20; wr_data = 12'hF00;
    at_neg();
    chk("wr_ready", 32'(wr_ready), 32'h1);
    chk("wr_we", 32'(ram_we), 32'h1);
    chk("wr_addr", 32'(ram_addr), 32'h01414);
    step();
    wr_valid = 0; disp_req = 1; disp_h = 10'd10; disp_v = 9'd20;
    step();
    disp_req = 0;
    at_neg();
    chk("wr_readback", 32'(pix_data), 32'hF00);

    // Conflict: display holds the port for 3 cycles
    step();
    wr_valid = 1; wr_h = 10'd1; wr_v = 9'd1; wr_data = 12'h123;
    disp_req = 1; disp_h = 10'd5; disp_v = 9'd3;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("conflict_ready", 32'(wr_ready), 32'h0);
      step();
    end
    disp_req = 0;
    at_neg();
    chk("conflict_ready4", 32'(wr_ready), 32'h1);
    chk("conflict_we4", 32'(ram_we), 32'h1);
`ifdef VRAM_ARB_STALL_CNT_EN
    chk("conflict_stall", 32'(stall_cnt), 32'd3);
`else
    chk("conflict_stall", 32'(stall_cnt), 32'd0);
`endif
    step();
    wr_valid = 0;

    // Plain clear
    run_clear(12'h0F0, 12, nb, nd);
    chk("clr_busy_cycles", 32'(nb), 32'd8);
    chk("clr_done_pulses", 32'(nd), 32'd1);
    readback(12'h0F0, "clr_cell");

    // Clear interleaved with display reads; a mid-clear start is ignored
    clr_start = 1; clr_color = 12'h00F;
    step();
    clr_start = 0;
    nb = 0; nd = 0;
    disp_h = 10'd5; disp_v = 9'd3;
    for (int i = 0; i < 20; i++) begin
      disp_req  = (i % 2 == 0);
      clr_start = (i == 5);
      if (i == 5) clr_color = 12'h111;
      at_neg();
      nb += int'(busy); nd += int'(clr_done);
      step();
    end
    disp_req = 0; clr_start = 0;
    chk("ilv_busy_cycles", 32'(nb), 32'd16);
    chk("ilv_done_pulses", 32'(nd), 32'd1);
    readback(12'h00F, "ilv_cell");

    // Reset after 3 clear writes
    clr_start = 1; clr_color = 12'h0AA;
    step();
    clr_start = 0;
    step(); step(); step();
    reset = 1;
    step();
    reset = 0;
    at_neg();
    chk("abort_busy", 32'(busy), 32'h0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      nd += int'(clr_done);
      step();
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run_clear(12'h0F0, 12, nb, nd);
    chk("reclr_busy_cycles", 32'(nb), 32'd8);
    chk("reclr_done_pulses", 32'(nd), 32'd1);
    readback(12'h0F0, "reclr_cell");

    step();
    started = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video RAM (12-bit pixels, address {h[9:0], v[8:0]}) among three users:
  - display scan-out reads from vga_ctrl (hard priority);
  - a pixel writer on a valid/ready handshake;
  - an internal screen-clear engine.
- Sits between vga_ctrl, the pixel producer and vga_ram, in the 25 MHz pixel-clock domain.

Parameters:
- H_W, 10, horizontal address width.
- V_W, 9, vertical address width.
- DW, 12, pixel width (4:4:4 RGB).
- H_MAX, 640, visible columns swept by clear.
- V_MAX, 480, visible rows swept by clear.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- disp_req  in  1  display wants a read this cycle (vga_ctrl valid).
- disp_h  in  H_W  display column.
- disp_v  in  V_W  display row.
- pix_data  out  DW  pixel to vga_ctrl.
- pix_valid  out  1  pix_data holds a display read result.
- wr_valid  in  1  writer request.
- wr_ready  out  1  write accepted this cycle when wr_valid is also high.
- wr_h  in  H_W  write column.
- wr_v  in  V_W  write row.
- wr_data  in  DW  write pixel.
- clr_start  in  1  one-cycle pulse; start full-screen clear.
- clr_color  in  DW  fill colour, sampled on clr_start.
- busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.
- stall_cnt  out  16  writer stall counter (optional feature).
- ram_addr  out  H_W+V_W  {h, v} to RAM.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data, 1-cycle latency.

Behaviour:
- FSM: IDLE, CLEAR. Reset forces IDLE, clear counters to 0, pix_valid=0, busy=0, clr_done=0, stall_cnt=0. RAM-port outputs and wr_ready are combinational, decoded from FSM state and current inputs.
- Slot selection each cycle, in priority order:
  1. reset=1: ram_en=0, ram_we=0, wr_ready=0.
  2. disp_req=1: ram_addr={disp_h,disp_v}, ram_en=1, ram_we=0.
  3. CLEAR and disp_req=0: ram_addr={ch,cv}, ram_din=latched colour, ram_en=1, ram_we=1.
  4. IDLE, disp_req=0, wr_valid=1: ram_addr={wr_h,wr_v}, ram_din=wr_data, ram_en=1, ram_we=1.
  5. Otherwise: ram_en=0, ram_we=0; ram_addr/ram_din are don't-care (drive 0).
- wr_ready = !reset && state==IDLE && !disp_req. It does not depend on wr_valid. A transfer happens on wr_valid && wr_ready and completes in that cycle.
- Writer must hold wr_h, wr_v, wr_data stable while wr_valid=1 && wr_ready=0.
- Display latency:
  - pix_valid is disp_req registered (one cycle later).
  - pix_data = ram_dout when pix_valid=1, else 0 (black in blanking).
- Clear sequencing:
  - In IDLE, clr_start=1 latches clr_color, sets ch=0, cv=0, and enters CLEAR next cycle.
  - If wr_valid is also accepted in that cycle, the write proceeds and is later overwritten by the clear.
  - In CLEAR, each granted slot (disp_req=0) writes, then advances:
    - ch < H_MAX-1: ch+1;
    - ch = H_MAX-1 and cv < V_MAX-1: ch=0, cv+1;
    - ch = H_MAX-1 and cv = V_MAX-1: return to IDLE, clr_done=1 for the next cycle only.
  - Cycles with disp_req=1 stall the counters.
  - busy = (state==CLEAR).
  - clr_start during CLEAR is ignored (no restart, colour unchanged).
- Counters ch/cv are sized H_W/V_W. H_MAX ≤ 2^H_W and V_MAX ≤ 2^V_W.
- Reset mid-clear: abort immediately, IDLE next cycle, no clr_done pulse. RAM contents are undefined for the partially cleared area.
- disp_req high continuously: writer and clear starve indefinitely. This is legal; there is no timeout.

Optional Feature:
- Macro VRAM_ARB_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on each cycle with wr_valid=1 && wr_ready=0. It saturates at 16'hFFFF and clears on reset.
- Undefined: stall_cnt tied to 0 and no counter logic is synthesised.

Test Plan:
- Display read: disp_req=1 at (h=5,v=3) with RAM preloaded 12'hABC → ram_addr=19'h00A03, ram_we=0; next cycle pix_valid=1, pix_data=12'hABC. With disp_req=0 → pix_data=0.
- Write handshake: disp_req=0, wr_valid=1, (h=10,v=20,data=12'hF00) → wr_ready=1, ram_we=1, ram_addr=19'h01414. A later display read of (10,20) returns 12'hF00.
- Conflict: disp_req=1 for 3 cycles while wr_valid=1 → wr_ready=0 for all 3. The write completes on the 4th cycle. stall_cnt=3 with macro defined, 0 without.
- Clear (H_MAX=4, V_MAX=2): clr_start with clr_color=12'h0F0 and disp_req=0 → busy=1 for exactly 8 cycles, writes (0,0)…(3,0),(0,1)…(3,1). clr_done pulses once, and all 8 cells read 12'h0F0.
- Clear with display interleave: disp_req toggling 1/0 during clear → clear takes 16 cycles and display reads return correct data. clr_start issued mid-clear is ignored.
- Reset mid-clear after 3 writes → busy=0 the next cycle and no clr_done pulse. A new clr_start afterwards completes normally.
